// File: rtl/label_neighbourhood.sv
// label_neighbourhood: streaming front end for a connected-components labeler.
// Takes one binarized pixel per valid cycle in raster order. It tracks the
// pixel position and presents the pixel with its causal neighbour labels
// A (x-1,y-1), B (x,y-1), C (x+1,y-1) and D (x-1,y). These come from a
// one-row line buffer that is fed back from the labeler output q.
// Resolved labels are re-emitted as a registered stream.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   sof, pixel_valid      start of frame (qualified), pixel strobe
//   pixel_in              binarized pixel (nonzero = foreground)
//   q                     label returned combinationally for the presented pixel
//   en                    neighbourhood outputs valid this cycle
//   data, A, B, C, D      presented pixel and neighbour labels (0 = none)
//   x, y                  presented pixel coordinates, zero-extended to 32 bits
//   label_out/label_valid label stream captured from q
//   frame_done            one-cycle pulse with the label of the last pixel
module label_neighbourhood #(
  parameter int WORD_SIZE = 8,
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sof,
  input  logic                 pixel_valid,
  input  logic [WORD_SIZE-1:0] pixel_in,
  input  logic [WORD_SIZE-1:0] q,
  output logic                 en,
  output logic [WORD_SIZE-1:0] data,
  output logic [WORD_SIZE-1:0] A,
  output logic [WORD_SIZE-1:0] B,
  output logic [WORD_SIZE-1:0] C,
  output logic [WORD_SIZE-1:0] D,
  output logic [31:0]          x,
  output logic [31:0]          y,
  output logic [WORD_SIZE-1:0] label_out,
  output logic                 label_valid,
  output logic                 frame_done
);

  localparam int AW = $clog2(WIDTH);
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [AW-1:0] XMAX  = AW'(WIDTH - 1);
  localparam logic [AW-1:0] XWRAP = AW'(WIDTH - 2);
  localparam logic [RW-1:0] YMAX  = RW'(HEIGHT - 1);
  localparam logic [WORD_SIZE-1:0] ZERO_LABEL = {WORD_SIZE{1'b0}};

  // Position counters for the next accepted pixel
  logic [AW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Presented-pixel registers
  logic                 en_q;
  logic [WORD_SIZE-1:0] data_q;
  logic [WORD_SIZE-1:0] a_q, b_q, c_q, d_q;
  logic [WORD_SIZE-1:0] a_d, b_d, c_d, d_d;
  logic [AW-1:0]        x_q;
  logic [RW-1:0]        y_q;

  // Label of the most recently presented pixel, kept across stalls for D
  logic [WORD_SIZE-1:0] q_hold_q;

  // Label stream
  logic [WORD_SIZE-1:0] label_q;
  logic                 label_valid_q;
  logic                 frame_done_q;

  // Line buffer and two-deep prefetch pipeline (pf1 is the older read)
  logic [WORD_SIZE-1:0] line_mem [0:WIDTH-1];
  logic [WORD_SIZE-1:0] pf0_q, pf1_q;

  logic [AW-1:0]        pos_col_s;
  logic [RW-1:0]        pos_row_s;
  logic [AW-1:0]        rd_addr_s;
  logic [WORD_SIZE-1:0] prev_label_s;

  // Accepted-pixel position, counter advance, prefetch address and neighbours
  always_comb begin
    pos_col_s    = col_q;
    pos_row_s    = row_q;
    col_d        = col_q;
    row_d        = row_q;
    rd_addr_s    = col_q;
    prev_label_s = q_hold_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    d_d          = d_q;

    if (sof) begin
      pos_col_s = {AW{1'b0}};
      pos_row_s = {RW{1'b0}};
    end else begin
      pos_col_s = col_q;
      pos_row_s = row_q;
    end

    if (pos_col_s == XMAX) begin
      col_d = {AW{1'b0}};
      if (pos_row_s == YMAX) begin
        row_d = {RW{1'b0}};
      end else begin
        row_d = pos_row_s + RW'(1);
      end
    end else begin
      col_d = pos_col_s + AW'(1);
      row_d = pos_row_s;
    end

    // Read column col+2 modulo WIDTH. The reads issued by the last two
    // pixels of a row fetch columns 0 and 1, which the next row start needs.
    if (pos_col_s >= XWRAP) begin
      rd_addr_s = pos_col_s - XWRAP;
    end else begin
      rd_addr_s = pos_col_s + AW'(2);
    end

    // While en is high, q is still the live label of the previous pixel.
    if (en_q) begin
      prev_label_s = q;
    end else begin
      prev_label_s = q_hold_q;
    end

    if (pos_col_s == {AW{1'b0}}) begin
      a_d = ZERO_LABEL;
      b_d = pf1_q;
      c_d = pf0_q;
      d_d = ZERO_LABEL;
    end else begin
      a_d = b_q;
      b_d = c_q;
      c_d = pf0_q;
      d_d = prev_label_s;
    end

    if (pos_row_s == {RW{1'b0}}) begin
      a_d = ZERO_LABEL;
      b_d = ZERO_LABEL;
      c_d = ZERO_LABEL;
    end else begin
      a_d = a_d;
    end

    if (pos_col_s == XMAX) begin
      c_d = ZERO_LABEL;
    end else begin
      c_d = c_d;
    end
  end

  // Line buffer write of resolved labels and prefetch read (RAM-style, no reset)
  always_ff @(posedge clk) begin
    if (en_q) begin
      line_mem[x_q] <= q;
    end
    if (pixel_valid) begin
      pf0_q <= line_mem[rd_addr_s];
      pf1_q <= pf0_q;
    end
  end

  // Counters, presented-pixel registers and label stream
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_q         <= {AW{1'b0}};
      row_q         <= {RW{1'b0}};
      en_q          <= 1'b0;
      data_q        <= ZERO_LABEL;
      a_q           <= ZERO_LABEL;
      b_q           <= ZERO_LABEL;
      c_q           <= ZERO_LABEL;
      d_q           <= ZERO_LABEL;
      x_q           <= {AW{1'b0}};
      y_q           <= {RW{1'b0}};
      q_hold_q      <= ZERO_LABEL;
      label_q       <= ZERO_LABEL;
      label_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      en_q <= pixel_valid;
      if (pixel_valid) begin
        col_q  <= col_d;
        row_q  <= row_d;
        data_q <= pixel_in;
        a_q    <= a_d;
        b_q    <= b_d;
        c_q    <= c_d;
        d_q    <= d_d;
        x_q    <= pos_col_s;
        y_q    <= pos_row_s;
      end
      if (en_q) begin
        q_hold_q      <= q;
        label_q       <= q;
        label_valid_q <= 1'b1;
      end else begin
        label_valid_q <= 1'b0;
      end
      frame_done_q <= en_q && (x_q == XMAX) && (y_q == YMAX);
    end
  end

  assign en          = en_q;
  assign data        = data_q;
  assign A           = a_q;
  assign B           = b_q;
  assign C           = c_q;
  assign D           = d_q;
  assign x           = {{(32-AW){1'b0}}, x_q};
  assign y           = {{(32-RW){1'b0}}, y_q};
  assign label_out   = label_q;
  assign label_valid = label_valid_q;
  assign frame_done  = frame_done_q;

endmodule
